// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver (start bit, DATA_WIDTH data bits LSB
// first, one stop bit, no parity). It samples each bit near mid-period and
// validates the stop bit.
//
// Ports
//   clk        system clock; all logic runs on the rising edge
//   arst       asynchronous reset, active-high
//   rx         serial line, idles high, asynchronous to clk
//   data       last good received word; held until the next good frame
//   dv         one-cycle pulse when data is updated
//   frame_err  one-cycle pulse when the stop bit is sampled low (frame dropped)
//   active     high from start-bit detect until the frame is finished
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line idle, waiting for rx_s low
// START   | timing to mid start bit, rejecting short glitches
// DATA    | sampling data bits one bit period apart
// STOP    | sampling the stop bit, publishing data or flagging an error
// CLEANUP | one cycle to drop the pulses before re-arming
module uart_rx #(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  dv,
    output logic                  frame_err,
    output logic                  active
);

    localparam int N  = CLOCK_RATE / BAUD_RATE;
    localparam int H  = (N - 1) / 2;
    localparam int CW = $clog2(N);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_H    = CW'(H);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [1:0]            sync;
    logic                  rx_s;
    logic [CW-1:0]         clk_cnt, clk_cnt_nxt;
    logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  dv_nxt, frame_err_nxt, active_nxt;

    // Two-flop synchroniser; resets to the idle level so that a reset
    // never looks like a start edge.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    assign rx_s = sync[1];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            dv        <= 1'b0;
            frame_err <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            clk_cnt   <= clk_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            data      <= data_nxt;
            dv        <= dv_nxt;
            frame_err <= frame_err_nxt;
            active    <= active_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clk_cnt_nxt   = clk_cnt;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        data_nxt      = data;
        dv_nxt        = 1'b0;
        frame_err_nxt = 1'b0;
        active_nxt    = active;

        case (state)
            IDLE: begin
                clk_cnt_nxt = '0;
                bit_cnt_nxt = '0;
                active_nxt  = 1'b0;
                if (!rx_s) begin
                    // The detect cycle itself counts as the first clock of
                    // the start bit, so the half-bit check lands H clocks
                    // after the edge is first seen.
                    state_nxt   = START;
                    clk_cnt_nxt = CW'(1);
                    active_nxt  = 1'b1;
                end
            end

            START: begin
                if (clk_cnt == CNT_H) begin
                    clk_cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt = DATA;
                    end else begin
                        state_nxt  = IDLE;
                        active_nxt = 1'b0;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CW'(1);
                end
            end

            DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt        = '0;
                    shreg_nxt[bit_cnt] = rx_s;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CW'(1);
                end
            end

            STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = CLEANUP;
                    active_nxt  = 1'b0;
                    if (rx_s) begin
                        data_nxt = shreg;
                        dv_nxt   = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CW'(1);
                end
            end

            CLEANUP: begin
                state_nxt  = IDLE;
                active_nxt = 1'b0;
            end

            default: begin
                state_nxt   = IDLE;
                clk_cnt_nxt = '0;
                bit_cnt_nxt = '0;
                active_nxt  = 1'b0;
            end
        endcase
    end

endmodule
